// File: rtl/register_bank.sv
// Register bank: DEPTH x WIDTH registers with a write port, in-place inc/dec and two tri-state read ports.
// Optional REGBANK_BYPASS_EN forwards same-cycle write data onto a read port whose address matches.
module register_bank #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             w,
  input  logic [AW-1:0]    wa,
  input  logic [1:0]       cnt_op,
  input  logic [AW-1:0]    ca,
  input  logic [AW-1:0]    raa,
  input  logic             rea,
  output wire  [WIDTH-1:0] douta,
  input  logic [AW-1:0]    rab,
  input  logic             reb,
  output wire  [WIDTH-1:0] doutb,
  output logic             wrap
);

  localparam int unsigned NSLOT = 1 << AW;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10,
    CNT_RSVD = 2'b11
  } cnt_op_e;

  // One bit per address slot: set when the slot maps onto a physical register.
  function automatic logic [NSLOT-1:0] valid_mask_f();
    logic [NSLOT-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NSLOT; i++) m[i] = (i < DEPTH);
    return m;
  endfunction

  localparam logic [NSLOT-1:0] VALID_MASK = valid_mask_f();

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_hit;
  logic             cnt_act;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt_cur;
  logic [WIDTH-1:0] cnt_val;
  logic             wrap_d;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  cnt_op_e          op;

  // Write/count decode; a write to the counted register cancels the count and its wrap.
  always_comb begin
    op      = cnt_op_e'(cnt_op);
    wr_hit  = w && VALID_MASK[wa];
    cnt_inc = (op == CNT_INC);
    cnt_act = ((op == CNT_INC) || (op == CNT_DEC)) && VALID_MASK[ca] && !(w && (wa == ca));
    cnt_cur = VALID_MASK[ca] ? regs[ca] : '0;
    cnt_val = cnt_inc ? (cnt_cur + WIDTH'(1)) : (cnt_cur - WIDTH'(1));
    wrap_d  = cnt_act && (cnt_inc ? (&cnt_cur) : (~|cnt_cur));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      wrap <= 1'b0;
    end else begin
      if (wr_hit)  regs[wa] <= din;
      if (cnt_act) regs[ca] <= cnt_val;
      wrap <= wrap_d;
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_a = VALID_MASK[raa] ? regs[raa] : '0;
    rd_b = VALID_MASK[rab] ? regs[rab] : '0;
`ifdef REGBANK_BYPASS_EN
    if (wr_hit && (wa == raa)) rd_a = din;
    if (wr_hit && (wa == rab)) rd_b = din;
`endif
  end

  assign douta = rea ? {WIDTH{1'bz}} : rd_a;
  assign doutb = reb ? {WIDTH{1'bz}} : rd_b;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus queues expected values, a negedge monitor pops and compares.
// Disabled read ports float to Z; the nets carry a pull-up so Z is observed as all ones.
module tb_register_bank;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  localparam int K_A    = 0;
  localparam int K_B    = 1;
  localparam int K_WRAP = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             w;
  logic [AW-1:0]    wa;
  logic [1:0]       cnt_op;
  logic [AW-1:0]    ca;
  logic [AW-1:0]    raa;
  logic             rea;
  logic [AW-1:0]    rab;
  logic             reb;
  tri1  [WIDTH-1:0] douta_w;
  tri1  [WIDTH-1:0] doutb_w;
  logic             wrap;

  typedef struct {
    int               kind;
    logic [WIDTH-1:0] exp;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .w(w), .wa(wa), .cnt_op(cnt_op), .ca(ca),
    .raa(raa), .rea(rea), .douta(douta_w), .rab(rab), .reb(reb), .doutb(doutb_w), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [WIDTH-1:0] v, input string n);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: outputs are settled by the falling edge; check everything queued this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [WIDTH-1:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_A:     act = douta_w;
        K_B:     act = doutb_w;
        default: act = WIDTH'(wrap);
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; din = '0; w = 1'b0; wa = '0; cnt_op = 2'b00; ca = '0;
    raa = 3'd3; rea = 1'b0; rab = 3'd7; reb = 1'b0;

    // Reset: read ports live, registers and wrap cleared
    cyc();
    expect_val(K_A, 16'h0000, "rst_douta");
    expect_val(K_B, 16'h0000, "rst_doutb");
    expect_val(K_WRAP, 16'h0000, "rst_wrap");
    cyc();
    rea = 1'b1;
    expect_val(K_A, 16'hFFFF, "rst_rea_disabled");
    expect_val(K_B, 16'h0000, "rst_doutb_live");
    cyc();
    rea = 1'b0;
    rst_n = 1'b1;

    // Write/read with one-cycle latency
    cyc();
    w = 1'b1; wa = 3'd3; din = 16'hBEEF;
    cyc();
    w = 1'b0; raa = 3'd3; rab = 3'd3;
    expect_val(K_A, 16'hBEEF, "wr3_a");
    expect_val(K_B, 16'hBEEF, "wr3_b");
    cyc();
    raa = 3'd2;
    expect_val(K_A, 16'h0000, "rd2_zero");

    // Walk every register with unique data
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      w = 1'b1; wa = AW'(i); din = 16'h1000 + 16'(i) * 16'h0111;
    end
    cyc();
    w = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      raa = AW'(i); rab = AW'(DEPTH - 1 - i);
      expect_val(K_A, 16'h1000 + 16'(i) * 16'h0111, "walk_a");
      expect_val(K_B, 16'h1000 + 16'(DEPTH - 1 - i) * 16'h0111, "walk_b");
      cyc();
    end

    // Increment wrap
    w = 1'b1; wa = 3'd5; din = 16'hFFFF;
    cyc();
    w = 1'b0; cnt_op = 2'b01; ca = 3'd5; raa = 3'd5;
    expect_val(K_A, 16'hFFFF, "inc_pre");
    expect_val(K_WRAP, 16'h0000, "inc_pre_wrap");
    cyc();
    cnt_op = 2'b00;
    expect_val(K_A, 16'h0000, "inc_wrapped");
    expect_val(K_WRAP, 16'h0001, "inc_wrap_pulse");
    // Decrement wrap
    cyc();
    cnt_op = 2'b10;
    expect_val(K_WRAP, 16'h0000, "inc_wrap_end");
    cyc();
    cnt_op = 2'b00;
    expect_val(K_A, 16'hFFFF, "dec_wrapped");
    expect_val(K_WRAP, 16'h0001, "dec_wrap_pulse");
    cyc();
    expect_val(K_WRAP, 16'h0000, "dec_wrap_end");

    // Collision on the same register: write wins
    w = 1'b1; wa = 3'd2; din = 16'h0007;
    cyc();
    wa = 3'd2; ca = 3'd2; din = 16'h1234; cnt_op = 2'b01;
    cyc();
    w = 1'b0; cnt_op = 2'b00; raa = 3'd2;
    expect_val(K_A, 16'h1234, "coll_same_write_wins");
    expect_val(K_WRAP, 16'h0000, "coll_same_wrap");
    // Different registers: both happen
    w = 1'b1; wa = 3'd2; din = 16'h0007;
    cyc();
    wa = 3'd1; din = 16'h1234; ca = 3'd2; cnt_op = 2'b01;
    cyc();
    w = 1'b0; cnt_op = 2'b00; raa = 3'd1; rab = 3'd2;
    expect_val(K_A, 16'h1234, "coll_diff_write");
    expect_val(K_B, 16'h0008, "coll_diff_count");
    // Write over an all-ones register being incremented: no wrap
    w = 1'b1; wa = 3'd6; din = 16'hFFFF;
    cyc();
    wa = 3'd6; ca = 3'd6; din = 16'h0042; cnt_op = 2'b01;
    cyc();
    w = 1'b0; cnt_op = 2'b00; raa = 3'd6;
    expect_val(K_A, 16'h0042, "coll_ones_write");
    expect_val(K_WRAP, 16'h0000, "coll_ones_nowrap");

    // Same-cycle read of a register being written
    cyc();
    w = 1'b1; wa = 3'd4; din = 16'hA5A5; raa = 3'd4; rab = 3'd4; reb = 1'b1;
`ifdef REGBANK_BYPASS_EN
    expect_val(K_A, 16'hA5A5, "bypass_fwd");
`else
    expect_val(K_A, 16'h1444, "bypass_old");
`endif
    expect_val(K_B, 16'hFFFF, "reb_disabled");
    cyc();
    w = 1'b0; reb = 1'b0;
    expect_val(K_A, 16'hA5A5, "bypass_after_a");
    expect_val(K_B, 16'hA5A5, "bypass_after_b");

    // Async reset between edges while a write is pending
    cyc();
    w = 1'b1; wa = 3'd0; din = 16'hDEAD; raa = 3'd0; rab = 3'd4;
    #1;
    rst_n = 1'b0;
    expect_val(K_A, 16'h0000, "arst_reg0");
    expect_val(K_B, 16'h0000, "arst_reg4");
    cyc();
    expect_val(K_A, 16'h0000, "arst_nowrite");
    expect_val(K_WRAP, 16'h0000, "arst_wrap");
    cyc();
    rst_n = 1'b1; w = 1'b0;
    expect_val(K_A, 16'h0000, "arst_still_zero");
    cyc();
    w = 1'b1; wa = 3'd0; din = 16'h0BAD;
    cyc();
    w = 1'b0;
    expect_val(K_A, 16'h0BAD, "post_rst_write");

    cyc();
    cyc();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
